cavlc_bit_packer: RTL and testbench
===================================

Name: cavlc_bit_packer

Overview:
- Downstream of the CAVLC element encoders (coeff_token, trailing-ones, level, total_zeros, run_before).
- Accepts right-aligned variable-length codes of 0..25 bits, one per handshake, and concatenates them MSB-first into 32-bit stream words.
- At block end, flushes the partial final word zero-padded and flags how many of its bits are valid.
- Provides backpressure in both directions and a per-block bit count for rate control.

Parameters:
- CODE_W, 25, max code width / code_data width
- LEN_W, 5, code_len width
- WORD_W, 32, output word width
- ACC_W, 64, accumulator width; must be >= WORD_W + CODE_W - 1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- enc_rst  in  1  synchronous block clear; same effect as rst
- code_valid  in  1  code_data/code_len/code_last valid
- code_ready  out  1  packer accepts the code this cycle
- code_data  in  CODE_W  code, right-aligned; bits at and above code_len ignored
- code_len  in  LEN_W  code length 0..25
- code_last  in  1  final code of the block
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer takes word
- out_data  out  WORD_W  packed word; first code bit at bit 31
- out_last  out  1  final word of block
- out_nbits  out  6  valid bits in out_data, 1..32; 32 unless out_last
- block_done  out  1  one-cycle pulse; block fully emitted
- total_bits  out  16  bits accepted this block; saturates at 16'hFFFF

Behaviour:
- Reset (rst or enc_rst): acc=0, fill=0, state=RUN, out_valid=0, out_data=0, out_last=0, out_nbits=0, block_done=0, total_bits=0. Any pending code or word is discarded. rst and enc_rst have priority over all other events.
- State RUN:
  - code_ready = (fill < 32).
  - On accept, masked code is placed at acc bits [63-fill -: len]; fill += len; total_bits += len.
  - len 0 is accepted with no data change.
  - code_len > 25 saturates to 25.
  - code_last accepted -> FLUSH.
- State FLUSH: code_ready=0.
- State DONE:
  - code_ready=0; block_done=1 for exactly this one cycle.
  - Then -> RUN; acc, fill and total_bits cleared.
- Emit condition: (fill >= 32 in RUN, or fill > 0 in FLUSH) and (!out_valid || out_ready).
- On emit:
  - out_data <= acc[63:32]; acc <<= 32; fill -= min(fill,32); out_valid <= 1.
  - In FLUSH with fill <= 32: out_last <= 1, out_nbits <= fill, and unused low bits are 0. Otherwise out_nbits <= 32 and out_last <= 0.
- Accept (fill < 32) and emit-in-RUN (fill >= 32) are mutually exclusive. Max fill = 31 + 25 = 56, so the accumulator never overflows.
- out_valid && !out_ready: out_data, out_last and out_nbits hold stable. out_valid drops only on a handshake with no new emit in the same cycle.
- FLUSH -> DONE on the cycle when fill == 0 and the last word (if any) is handshaken (out_valid==0 or out_ready). If fill==0 at code_last, no word is emitted and DONE follows directly.
- Latency:
  - A code accepted at edge t updates fill at t.
  - A word becomes visible (out_valid=1) after the next edge on which the emit condition holds.
  - Sustained throughput is one code per cycle while the output drains.
- Back-to-back blocks: next block's codes are accepted starting the cycle after DONE.

Decomposition:
- Package cavlc_pkg holds:
  - CODE_W, LEN_W, WORD_W constants;
  - typedef packer_state_e {RUN, FLUSH, DONE};
  - a function mask_code(data, len).
- Optional sub-module cavlc_word_outreg: the output holding register with the valid/ready hold rule. All other logic stays in cavlc_bit_packer.

Test Plan:
- 32 codes of data=1, len=1, out_ready=1, last on 32nd -> one word 0xFFFFFFFF, out_last=1, out_nbits=32, block_done one cycle after handshake, total_bits=32.
- Code 25'h1FFFFFF len 25 then 7'b0000001 len 7, then 3'b101 len 3 last -> words 0xFFFFFF81 (last=0, nbits=32) then 0xA0000000 (last=1, nbits=3).
- out_ready=0, feed 2 codes of len 20 -> fill 40, code_ready=0 while the word waits; out_data stable; release out_ready -> word handshakes, code_ready returns 1.
- Single code len 0 with code_last -> no out_valid; block_done pulses 2 cycles after acceptance (FLUSH, DONE); total_bits=0.
- code_len 31 with data all-ones -> treated as 25: total_bits +25, 25 ones packed.
- enc_rst asserted with fill=17 and out_valid=1 -> next cycle out_valid=0, fill=0, total_bits=0, code_ready=1; following block packs from bit 31.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared constants, FSM state type and code-masking helper for the CAVLC bit packer.
package cavlc_pkg;

  localparam int CODE_W = 25;
  localparam int LEN_W  = 5;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } packer_state_e;

  // Clear every bit at or above len; lengths of CODE_W or more keep the full code.
  function automatic logic [CODE_W-1:0] mask_code(input logic [CODE_W-1:0] data,
                                                  input logic [LEN_W-1:0]  len);
    logic [CODE_W-1:0] m;
    m = (len >= LEN_W'(CODE_W)) ? '1 : ((CODE_W'(1) << len) - CODE_W'(1));
    return data & m;
  endfunction

endpackage

// File: rtl/cavlc_word_outreg.sv
// Output word holding register: loads on emit, holds while the consumer stalls.
module cavlc_word_outreg
  import cavlc_pkg::*;
(
  input  logic              clk,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_last,
  input  logic [5:0]        i_nbits,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data,
  output logic              o_last,
  output logic [5:0]        o_nbits
);

  logic              r_valid;
  logic [WORD_W-1:0] r_data;
  logic              r_last;
  logic [5:0]        r_nbits;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_nbits <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_nbits <= i_nbits;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_nbits = r_nbits;

endmodule

// File: rtl/cavlc_bit_packer.sv
// Concatenates right-aligned variable-length codes MSB-first into 32-bit words,
// flushing a zero-padded final word at block end.
module cavlc_bit_packer
  import cavlc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_rst,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code_data,
  input  logic [LEN_W-1:0]  code_len,
  input  logic              code_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic [5:0]        out_nbits,
  output logic              block_done,
  output logic [15:0]       total_bits
);

  packer_state_e     r_state, w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [6:0]        r_fill;
  logic [15:0]       r_total;

  logic              w_clear;
  logic [LEN_W-1:0]  w_len_sat;
  logic [ACC_W-1:0]  w_code_aligned;
  logic              w_accept;
  logic              w_out_valid;
  logic              w_out_free;
  logic              w_emit;
  logic              w_emit_last;
  logic [5:0]        w_emit_nbits;
  logic [16:0]       w_total_sum;

  assign w_clear   = rst || enc_rst;
  assign w_len_sat = (code_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : code_len;

  // Left-justify the masked code at bit 63, then slide it down past the bits already held.
  assign w_code_aligned = ({mask_code(code_data, w_len_sat), {(ACC_W-CODE_W){1'b0}}}
                           << (LEN_W'(CODE_W) - w_len_sat)) >> r_fill;

  assign code_ready  = (r_state == RUN) && (r_fill < 7'd32);
  assign w_accept    = code_valid && code_ready;
  assign w_out_free  = !w_out_valid || out_ready;
  assign w_emit      = ((r_state == RUN && r_fill >= 7'd32) ||
                        (r_state == FLUSH && r_fill != 7'd0)) && w_out_free;
  assign w_emit_last  = (r_state == FLUSH) && (r_fill <= 7'd32);
  assign w_emit_nbits = w_emit_last ? r_fill[5:0] : 6'd32;
  assign w_total_sum  = {1'b0, r_total} + 17'(w_len_sat);

  always_ff @(posedge clk) begin
    if (w_clear) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_accept && code_last)           w_state_nxt = FLUSH;
      FLUSH:   if (r_fill == 7'd0 && w_out_free)    w_state_nxt = DONE;
      DONE:                                         w_state_nxt = RUN;
      default:                                      w_state_nxt = RUN;
    endcase
  end

  // Accept needs fill < 32 and a RUN-state emit needs fill >= 32, so at most one fires.
  always_ff @(posedge clk) begin
    if (w_clear || r_state == DONE) begin
      r_acc   <= '0;
      r_fill  <= '0;
      r_total <= '0;
    end else if (w_emit) begin
      r_acc  <= r_acc << WORD_W;
      r_fill <= r_fill - ((r_fill >= 7'd32) ? 7'd32 : r_fill);
    end else if (w_accept) begin
      r_acc   <= r_acc | w_code_aligned;
      r_fill  <= r_fill + 7'(w_len_sat);
      r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
    end
  end

  cavlc_word_outreg u_outreg (
    .clk     (clk),
    .i_clear (w_clear),
    .i_load  (w_emit),
    .i_data  (r_acc[ACC_W-1 -: WORD_W]),
    .i_last  (w_emit_last),
    .i_nbits (w_emit_nbits),
    .i_ready (out_ready),
    .o_valid (w_out_valid),
    .o_data  (out_data),
    .o_last  (out_last),
    .o_nbits (out_nbits)
  );

  assign out_valid  = w_out_valid;
  assign block_done = (r_state == DONE);
  assign total_bits = r_total;

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Directed bench for cavlc_bit_packer: hand-computed words, flags, timing and bit counts.
module tb_cavlc_bit_packer;

  logic        clk = 1'b0;
  logic        rst, enc_rst;
  logic        code_valid, code_ready;
  logic [24:0] code_data;
  logic [4:0]  code_len;
  logic        code_last;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [5:0]  out_nbits;
  logic        block_done;
  logic [15:0] total_bits;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [15:0] done_total = '0;
  logic [38:0] q_words[$];

  cavlc_bit_packer dut (
    .clk        (clk),
    .rst        (rst),
    .enc_rst    (enc_rst),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_data  (code_data),
    .code_len   (code_len),
    .code_last  (code_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_nbits  (out_nbits),
    .block_done (block_done),
    .total_bits (total_bits)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Inputs change just after posedge, so values seen here are what the next edge samples.
  always @(negedge clk) begin
    if (!rst && !enc_rst) begin
      if (out_valid && out_ready) begin
        q_words.push_back({out_data, out_last, out_nbits});
        hs_cyc = cyc;
      end
      if (block_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_total = total_bits;
      end
    end
  end

  task automatic send(input logic [24:0] d, input logic [4:0] l, input logic last,
                      output int acc_cyc);
    bit ok = 0;
    acc_cyc = -1;
    code_valid = 1'b1; code_data = d; code_len = l; code_last = last;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (code_ready) begin ok = 1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    code_valid = 1'b0; code_last = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL send_timeout: code never accepted (len %0d)", l); end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 80 && done_cnt < target; i++) @(negedge clk);
    n_cmp++;
    if (done_cnt < target) begin
      n_bad++; $display("FAIL done_timeout: done_cnt=%0d required=%0d", done_cnt, target);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_words(input string name, input logic [38:0] exp[$]);
    n_cmp++;
    if (q_words.size() !== exp.size()) begin
      n_bad++; $display("FAIL %s_count: got %0d words required %0d", name, q_words.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (i >= q_words.size() || q_words[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL %s_word%0d: got %h required %h (data,last,nbits)", name, i,
                 (i < q_words.size()) ? q_words[i] : 39'h0, exp[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enc_rst = 1'b0; code_valid = 1'b1; code_data = '1; code_len = 5'd25;
    code_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 code_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, out_last, out_nbits, block_done, total_bits, code_ready} !==
        {1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 16'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b data=%h last=%b nbits=%0d done=%b total=%0d ready=%b required 0/0/0/0/0/0/1",
               out_valid, out_data, out_last, out_nbits, block_done, total_bits, code_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_ones;
    int a;
    int base = done_cnt;
    q_words.delete();
    out_ready = 1'b1;
    for (int k = 1; k <= 32; k++) send(25'h1, 5'd1, k == 32, a);
    wait_done(base + 1);
    check_words("ones", '{{32'hFFFFFFFF, 1'b1, 6'd32}});
    n_cmp++;
    if (done_cyc !== hs_cyc + 1) begin
      n_bad++; $display("FAIL ones_done_timing: done at %0d required %0d", done_cyc, hs_cyc + 1);
    end
    n_cmp++;
    if (done_total !== 16'd32) begin
      n_bad++; $display("FAIL ones_total: got %0d required 32", done_total);
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (done_cnt !== base + 1 || total_bits !== 16'd0) begin
      n_bad++; $display("FAIL ones_pulse_once: done_cnt=%0d total=%0d required %0d / 0", done_cnt, total_bits, base + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed;
    int a;
    int base = done_cnt;
    q_words.delete();
    out_ready = 1'b1;
    send(25'h1FFFFFF, 5'd25, 1'b0, a);
    send(25'h0000001, 5'd7, 1'b0, a);
    send(25'h0000005, 5'd3, 1'b1, a);
    wait_done(base + 1);
    check_words("mixed", '{{32'hFFFFFF81, 1'b0, 6'd32}, {32'hA0000000, 1'b1, 6'd3}});
    n_cmp++;
    if (done_total !== 16'd35) begin
      n_bad++; $display("FAIL mixed_total: got %0d required 35", done_total);
    end
  endtask

  task automatic test_backpressure;
    int a;
    int base = done_cnt;
    q_words.delete();
    out_ready = 1'b0;
    send(25'hABCDE, 5'd20, 1'b0, a);
    send(25'h12345, 5'd20, 1'b0, a);
    @(negedge clk);
    n_cmp++;
    if (code_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready_fill40: got %b required 0", code_ready);
    end
    @(posedge clk); #1;
    send(25'h6789A, 5'd20, 1'b0, a);
    send(25'hBCDEF, 5'd20, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({code_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'hABCDE123}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: ready=%b valid=%b data=%h required 0/1/abcde123", i, code_ready, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (code_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_ready_release: got %b required 1", code_ready);
    end
    @(posedge clk); #1;
    send(25'h0, 5'd0, 1'b1, a);
    wait_done(base + 1);
    check_words("bp", '{{32'hABCDE123, 1'b0, 6'd32}, {32'h456789AB, 1'b0, 6'd32},
                        {32'hCDEF0000, 1'b1, 6'd16}});
    n_cmp++;
    if (done_total !== 16'd80) begin
      n_bad++; $display("FAIL bp_total: got %0d required 80", done_total);
    end
  endtask

  task automatic test_len0;
    int a;
    int base = done_cnt;
    q_words.delete();
    out_ready = 1'b1;
    send(25'h1FFFFFF, 5'd0, 1'b1, a);
    wait_done(base + 1);
    check_words("len0", '{});
    n_cmp++;
    if (done_cyc !== a + 2 || done_total !== 16'd0) begin
      n_bad++; $display("FAIL len0_done: at %0d total %0d required %0d / 0", done_cyc, done_total, a + 2);
    end
  endtask

  task automatic test_len_sat;
    int a;
    int base = done_cnt;
    q_words.delete();
    out_ready = 1'b1;
    send(25'h1FFFFFF, 5'd31, 1'b0, a);
    @(negedge clk);
    n_cmp++;
    if (total_bits !== 16'd25) begin
      n_bad++; $display("FAIL sat_total: got %0d required 25", total_bits);
    end
    @(posedge clk); #1;
    send(25'h1FFFFFF, 5'd3, 1'b1, a);
    wait_done(base + 1);
    check_words("sat", '{{32'hFFFFFFF0, 1'b1, 6'd28}});
  endtask

  task automatic test_enc_rst;
    int a;
    int base = done_cnt;
    q_words.delete();
    out_ready = 1'b0;
    send(25'h1FFFFFF, 5'd25, 1'b0, a);
    send(25'h0FFFFFF, 5'd24, 1'b0, a);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || total_bits !== 16'd49) begin
      n_bad++; $display("FAIL erst_pre: valid=%b total=%0d required 1 / 49", out_valid, total_bits);
    end
    @(posedge clk); #1 enc_rst = 1'b1;
    @(posedge clk); #1 enc_rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, total_bits, code_ready} !== {1'b0, 32'h0, 16'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL erst_clear: valid=%b data=%h total=%0d ready=%b required 0/0/0/1", out_valid, out_data, total_bits, code_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(25'h5, 5'd3, 1'b1, a);
    wait_done(base + 1);
    check_words("erst", '{{32'hA0000000, 1'b1, 6'd3}});
  endtask

  task automatic test_back_to_back;
    int a;
    int base = done_cnt;
    q_words.delete();
    out_ready = 1'b1;
    send(25'hFF, 5'd8, 1'b1, a);
    send(25'h5, 5'd4, 1'b1, a);
    wait_done(base + 2);
    check_words("b2b", '{{32'hFF000000, 1'b1, 6'd8}, {32'h50000000, 1'b1, 6'd4}});
    n_cmp++;
    if (done_total !== 16'd4) begin
      n_bad++; $display("FAIL b2b_total: got %0d required 4", done_total);
    end
  endtask

  initial begin
    code_valid = 1'b0; code_data = '0; code_len = '0; code_last = 1'b0;
    out_ready = 1'b0; enc_rst = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_ones;
    test_mixed;
    test_backpressure;
    test_len0;
    test_len_sat;
    test_enc_rst;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
